joy_db9md_multi: RTL and testbench

- Parametrised successor of the DB9 Megadrive splitter reader. Time-multiplexes 1–4 DB9 ports over one shared 6-bit input bus and a port-select output.
- Runs the Megadrive SELECT sequence for every port in parallel and classifies each pad as 1-button/SMS, 3-button MD or 6-button MD.
- Publishes one 12-bit active-high button word per port, updated atomically once per frame.
- Sits between the DB9 pins and the core's joystick mux. Fully synchronous to the system clock: no derived clocks.

---
 rtl/joy_db9md_multi_if.sv | 25 ++
 rtl/joy_db9md_multi.sv | 157 +++++++++++++++
 tb/tb_joy_db9md_multi.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/joy_db9md_multi_if.sv
// Pin-side and core-side signals of the multiplexed DB9 Megadrive reader.
// The master modport is the reader; the slave modport is the pad/pin side.
interface joy_db9md_multi_if #(
    parameter int NUM_PORTS = 2
);
    localparam int SPW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    logic [5:0]              joy_in;
    logic                    joy_mdsel;
    logic [SPW-1:0]          joy_split;
    logic [12*NUM_PORTS-1:0] joystick;
    logic [NUM_PORTS-1:0]    pad_md;
    logic [NUM_PORTS-1:0]    pad_6btn;
    logic                    frame_valid;

    modport master (
        input  joy_in,
        output joy_mdsel, joy_split, joystick, pad_md, pad_6btn, frame_valid
    );

    modport slave (
        output joy_in,
        input  joy_mdsel, joy_split, joystick, pad_md, pad_6btn, frame_valid
    );
endinterface

// File: rtl/joy_db9md_multi.sv
// Time-multiplexed Megadrive pad reader for 1..4 DB9 ports sharing one 6-bit pin bus.
// Runs the SELECT sequence, classifies each pad, and publishes all ports once per frame.
module joy_db9md_multi #(
    parameter int NUM_PORTS  = 2,
    parameter int PHASE_DIV  = 64,
    parameter int SEL_DIV    = 256,
    parameter int IDLE_STEPS = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    joy_db9md_multi_if.master     bus
);
    localparam int SPW   = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int PW    = $clog2(PHASE_DIV);
    localparam int SW    = $clog2(SEL_DIV);
    localparam int STEPS = 8 + IDLE_STEPS;
    localparam int STW   = $clog2(STEPS);
    localparam logic [STW-1:0] LAST_STEP = STW'(STEPS - 1);

    if (NUM_PORTS < 1 || NUM_PORTS > 4) begin : g_bad_ports
        $fatal(1, "joy_db9md_multi: NUM_PORTS must be 1..4");
    end
    if (PHASE_DIV < 4) begin : g_bad_phase
        $fatal(1, "joy_db9md_multi: PHASE_DIV must be >= 4");
    end
    if (SEL_DIV < 2 * NUM_PORTS * PHASE_DIV) begin : g_bad_sel
        $fatal(1, "joy_db9md_multi: SEL_DIV must be >= 2*NUM_PORTS*PHASE_DIV");
    end
    if (IDLE_STEPS < 0) begin : g_bad_idle
        $fatal(1, "joy_db9md_multi: IDLE_STEPS must be >= 0");
    end

    logic [5:0]              sync1, sync2;
    logic [PW-1:0]           phase_cnt;
    logic [SPW-1:0]          split;
    logic [5:0]              latch [NUM_PORTS];
    logic [SW-1:0]           sel_cnt;
    logic [STW-1:0]          step;
    logic [STW-1:0]          step_nx;
    logic                    mdsel, mdsel_nx;
    logic [11:0]             work [NUM_PORTS];
    logic [NUM_PORTS-1:0]    md, six;
    logic [12*NUM_PORTS-1:0] joystick_q;
    logic [NUM_PORTS-1:0]    pad_md_q, pad_6btn_q;
    logic                    frame_valid_q;

    logic phase_last, step_last, frame_last;

    assign phase_last = (phase_cnt == PW'(PHASE_DIV - 1));
    assign step_last  = (sel_cnt == SW'(SEL_DIV - 1));
    assign frame_last = step_last && (step == LAST_STEP);

    // SELECT is low only on the odd steps of the 8-step sequence.
    always_comb begin
        step_nx  = (step == LAST_STEP) ? '0 : step + STW'(1);
        mdsel_nx = 1'b1;
        if (int'(step_nx) < 8) mdsel_nx = ~step_nx[0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1     <= '0;
            sync2     <= '0;
            phase_cnt <= '0;
            split     <= '0;
        end else begin
            sync1 <= bus.joy_in;
            sync2 <= sync1;
            if (phase_last) begin
                phase_cnt <= '0;
                split     <= (split == SPW'(NUM_PORTS - 1)) ? '0 : split + SPW'(1);
            end else begin
                phase_cnt <= phase_cnt + PW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int p = 0; p < NUM_PORTS; p++) latch[p] <= 6'h3F;
        end else if (phase_last) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (split == SPW'(p)) latch[p] <= sync2;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sel_cnt <= '0;
            step    <= '0;
            mdsel   <= 1'b1;
        end else if (step_last) begin
            sel_cnt <= '0;
            step    <= step_nx;
            mdsel   <= mdsel_nx;
        end else begin
            sel_cnt <= sel_cnt + SW'(1);
        end
    end

    // Decode uses the raw (active-low) latch for the MD signature tests
    // and its inverse for button values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int p = 0; p < NUM_PORTS; p++) work[p] <= '0;
            md  <= '0;
            six <= '0;
        end else if (step_last) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (step == STW'(0)) begin
                    work[p] <= {6'b0, ~latch[p]};
                    md[p]   <= 1'b0;
                    six[p]  <= 1'b0;
                end else if (step == STW'(1)) begin
                    if (latch[p][1:0] == 2'b00) begin
                        md[p]       <= 1'b1;
                        work[p][6]  <= ~latch[p][4];
                        work[p][10] <= ~latch[p][5];
                    end
                end else if (step == STW'(5)) begin
                    if (latch[p][3:0] == 4'b0000 && md[p]) six[p] <= 1'b1;
                end else if (step == STW'(6)) begin
                    if (six[p]) begin
                        work[p][9]  <= ~latch[p][0];
                        work[p][8]  <= ~latch[p][1];
                        work[p][7]  <= ~latch[p][2];
                        work[p][11] <= ~latch[p][3];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            joystick_q    <= '0;
            pad_md_q      <= '0;
            pad_6btn_q    <= '0;
            frame_valid_q <= 1'b0;
        end else begin
            frame_valid_q <= frame_last;
            if (frame_last) begin
                for (int p = 0; p < NUM_PORTS; p++) joystick_q[12*p +: 12] <= work[p];
                pad_md_q   <= md;
                pad_6btn_q <= six;
            end
        end
    end

    assign bus.joy_mdsel   = mdsel;
    assign bus.joy_split   = split;
    assign bus.joystick    = joystick_q;
    assign bus.pad_md      = pad_md_q;
    assign bus.pad_6btn    = pad_6btn_q;
    assign bus.frame_valid = frame_valid_q;
endmodule

// File: tb/tb_joy_db9md_multi.sv
// Directed bench for joy_db9md_multi with behavioural SMS / 3-button / 6-button pad models
// and a scoreboard of expected per-frame results.
module tb_joy_db9md_multi;
    localparam int NP = 2;

    typedef struct packed {
        logic [23:0] joy;
        logic [1:0]  md;
        logic [1:0]  six;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   n_vec = 0;
    int   n_err = 0;
    exp_t sb[$];

    // pad kinds: 0 open, 1 SMS, 2 MD 3-button, 3 MD 6-button
    int          kind [NP];
    logic [11:0] btn  [NP];
    int          pcnt   = 0;
    int          hi_run = 0;
    logic        sel_prev = 1'b1;

    joy_db9md_multi_if #(.NUM_PORTS(NP)) bus ();

    joy_db9md_multi #(
        .NUM_PORTS (NP),
        .PHASE_DIV (4),
        .SEL_DIV   (32),
        .IDLE_STEPS(4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [5:0] pad_pins(int k, logic [11:0] b, logic sel, int c);
        logic [5:0] pins;
        pins = 6'h3F;
        if (k == 1) begin
            pins = ~b[5:0];
        end else if (k >= 2) begin
            if (sel) begin
                if (k == 3 && c == 3) pins = ~{b[5], b[4], b[11], b[7], b[8], b[9]};
                else                  pins = ~b[5:0];
            end else begin
                if (k == 3 && c == 3)      pins = {~b[10], ~b[6], 4'b0000};
                else if (k == 3 && c == 4) pins = {~b[10], ~b[6], 4'b1111};
                else                       pins = {~b[10], ~b[6], ~b[3], ~b[2], 2'b00};
            end
        end
        return pins;
    endfunction

    // 6-button pads count SELECT falling edges and rearm after a long SELECT-high gap.
    always @(posedge clk) begin
        if (bus.joy_mdsel) begin
            hi_run <= hi_run + 1;
            if (hi_run >= 48) pcnt <= 0;
        end else begin
            hi_run <= 0;
            if (sel_prev) pcnt <= pcnt + 1;
        end
        sel_prev <= bus.joy_mdsel;
    end

    always @* begin
        bus.joy_in = pad_pins(kind[bus.joy_split], btn[bus.joy_split], bus.joy_mdsel, pcnt);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
            $error("miscompare %s", tag);
        end
    endtask

    task automatic wait_frame(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.frame_valid && n < 2000);
    endtask

    task automatic check_frame(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
        end else begin
            e = sb.pop_front();
            check({tag, "_joy"},  32'(bus.joystick), 32'(e.joy));
            check({tag, "_md"},   32'(bus.pad_md),   32'(e.md));
            check({tag, "_six"},  32'(bus.pad_6btn), 32'(e.six));
        end
    endtask

    initial begin
        int n;
        reset   = 1'b1;
        kind[0] = 0; kind[1] = 0;
        btn[0]  = '0; btn[1] = '0;

        repeat (64) @(negedge clk);
        check("rst_mdsel", 32'(bus.joy_mdsel),   32'd1);
        check("rst_split", 32'(bus.joy_split),   32'd0);
        check("rst_joy",   32'(bus.joystick),    32'd0);
        check("rst_md",    32'(bus.pad_md),      32'd0);
        check("rst_six",   32'(bus.pad_6btn),    32'd0);
        check("rst_fv",    32'(bus.frame_valid), 32'd0);

        reset = 1'b0;
        sb.push_back('{joy: 24'h000000, md: 2'b00, six: 2'b00});
        wait_frame(n);
        check("first_fv_delay", 32'(n), 32'd384);
        check_frame("idle");

        kind[0] = 2; btn[0] = 12'h018;
        sb.push_back('{joy: 24'h000018, md: 2'b01, six: 2'b00});
        wait_frame(n);
        check("fv_delay_md3", 32'(n), 32'd384);
        check_frame("md3");

        kind[1] = 3; btn[1] = 12'hE00;
        sb.push_back('{joy: 24'hE00018, md: 2'b11, six: 2'b10});
        wait_frame(n);
        check("fv_delay_md6", 32'(n), 32'd384);
        check_frame("md6");

        kind[0] = 1; btn[0] = 12'h030;
        sb.push_back('{joy: 24'hE00030, md: 2'b10, six: 2'b10});
        wait_frame(n);
        check_frame("sms");

        // One frame of split/SELECT timing, starting on the first clock of step 0.
        sb.push_back('{joy: 24'hE00030, md: 2'b10, six: 2'b10});
        for (int k = 0; k < 384; k++) begin
            int s;
            s = k / 32;
            check($sformatf("split_k%0d", k), 32'(bus.joy_split), 32'((k / 4) % 2));
            check($sformatf("mdsel_k%0d", k), 32'(bus.joy_mdsel),
                  (s < 8) ? 32'((s % 2) == 0) : 32'd1);
            if (k == 200) check("hold_mid_frame", 32'(bus.joystick), 32'h00E00030);
            if (k != 0)   check($sformatf("fv_low_k%0d", k), 32'(bus.frame_valid), 32'd0);
            @(negedge clk);
        end
        check("fv_period", 32'(bus.frame_valid), 32'd1);
        check_frame("timing");

        // Reset mid-frame with a pressed pad.
        kind[0] = 2; btn[0] = 12'h018;
        repeat (200) @(negedge clk);
        check("pre_reset_joy", 32'(bus.joystick), 32'h00E00030);
        reset = 1'b1;
        #1;
        check("midrst_joy",   32'(bus.joystick),    32'd0);
        check("midrst_md",    32'(bus.pad_md),      32'd0);
        check("midrst_six",   32'(bus.pad_6btn),    32'd0);
        check("midrst_mdsel", 32'(bus.joy_mdsel),   32'd1);
        check("midrst_split", 32'(bus.joy_split),   32'd0);
        check("midrst_fv",    32'(bus.frame_valid), 32'd0);
        repeat (64) @(negedge clk);
        reset = 1'b0;
        sb.push_back('{joy: 24'hE00018, md: 2'b11, six: 2'b10});
        wait_frame(n);
        check("fv_delay_after_rst", 32'(n), 32'd384);
        check_frame("after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
